// File: rtl/mode_counter_pkg.sv
// Shared constants and toggle-enable equations for the 3-bit up/down counter.
// Both flip-flop styles call toggle_vec so their next-state logic cannot diverge.
package mode_counter_pkg;

  localparam logic       MODE_UP     = 1'b0;
  localparam logic       MODE_DOWN   = 1'b1;
  localparam int         COUNT_W     = 3;
  localparam logic [2:0] RESET_VALUE = 3'b000;

  // A bit toggles when all lower bits are 1 (counting up) or all 0 (counting down).
  function automatic logic [COUNT_W-1:0] toggle_vec(input logic [COUNT_W-1:0] cnt,
                                                    input logic               mode);
    logic t1;
    t1 = cnt[0] ^ mode;
    return {t1 & (cnt[1] ^ mode), t1, 1'b1};
  endfunction

endpackage

// File: rtl/dff_sync.sv
// Plain rising-edge D flip-flop with no reset; reset is folded into d by the caller.
module dff_sync (
  input  logic clk,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk) begin
    q <= d;
  end

endmodule

// File: rtl/jkff_sync.sv
// Rising-edge JK flip-flop: 00 hold, 01 clear, 10 set, 11 toggle.
module jkff_sync (
  input  logic clk,
  input  logic j,
  input  logic k,
  output logic q
);

  always_ff @(posedge clk) begin
    case ({j, k})
      2'b00:   q <= q;
      2'b01:   q <= 1'b0;
      2'b10:   q <= 1'b1;
      default: q <= ~q;
    endcase
  end

endmodule

// File: rtl/mode_counter3.sv
// 3-bit synchronous up/down counter built from discrete D or JK flip-flops.
// FF_STYLE picks the storage primitive; both styles produce identical sequences.
module mode_counter3
  import mode_counter_pkg::*;
#(
  parameter int FF_STYLE = 0,
  parameter int WIDTH    = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mode,
  output logic [COUNT_W-1:0] count
);

  logic [COUNT_W-1:0] t_vec;
  logic [COUNT_W-1:0] q_bits;

  assign t_vec = toggle_vec(q_bits, mode);
  assign count = q_bits;

  generate
    if (WIDTH != COUNT_W) begin : g_bad_width
      $error("mode_counter3: WIDTH must be 3");
    end

    if (FF_STYLE == 0) begin : g_dff
      for (genvar gi = 0; gi < COUNT_W; gi++) begin : g_bit
        logic d_d;
        assign d_d = (q_bits[gi] ^ t_vec[gi]) & ~reset;
        dff_sync u_ff (
          .clk (clk),
          .d   (d_d),
          .q   (q_bits[gi])
        );
      end
    end else if (FF_STYLE == 1) begin : g_jkff
      for (genvar gi = 0; gi < COUNT_W; gi++) begin : g_bit
        // Reset forces J=0, K=1 (clear); otherwise J=K=T gives hold or toggle.
        logic j_d;
        logic k_d;
        assign j_d = t_vec[gi] & ~reset;
        assign k_d = t_vec[gi] | reset;
        jkff_sync u_ff (
          .clk (clk),
          .j   (j_d),
          .k   (k_d),
          .q   (q_bits[gi])
        );
      end
    end else begin : g_bad_style
      $error("mode_counter3: FF_STYLE must be 0 (D) or 1 (JK)");
    end
  endgenerate

endmodule

// File: tb/tb_mode_counter3.sv
// Self-checking bench: D and JK variants run side by side against an arithmetic
// model of the counter (reset -> 0, up -> +1 mod 8, down -> -1 mod 8).
module tb_mode_counter3;

  logic       clk;
  logic       reset;
  logic       mode;
  logic [2:0] count_d;
  logic [2:0] count_jk;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_cnt  = 0;

  mode_counter3 #(.FF_STYLE(0), .WIDTH(3)) dut_d (
    .clk   (clk),
    .reset (reset),
    .mode  (mode),
    .count (count_d)
  );

  mode_counter3 #(.FF_STYLE(1), .WIDTH(3)) dut_jk (
    .clk   (clk),
    .reset (reset),
    .mode  (mode),
    .count (count_jk)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply inputs on the falling edge, take one rising edge, sample 1 ns later.
  task automatic tick(input logic r, input logic m);
    @(negedge clk);
    reset = r;
    mode  = m;
    @(posedge clk);
    if (r)      exp_cnt = 0;
    else if (m) exp_cnt = (exp_cnt + 7) % 8;
    else        exp_cnt = (exp_cnt + 1) % 8;
    #1;
    $display("t=%0t reset=%0b mode=%0b count_d=%0d count_jk=%0d model=%0d",
             $time, r, m, count_d, count_jk, exp_cnt);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      tick(1'b1, 1'b0);
      n_checks++;
      if (count_d !== 3'd0) begin
        n_fail++;
        $display("FAIL reset_d[%0d]: got %0d expected 0", i, count_d);
      end
      n_checks++;
      if (count_jk !== 3'd0) begin
        n_fail++;
        $display("FAIL reset_jk[%0d]: got %0d expected 0", i, count_jk);
      end
    end
  endtask

  task automatic test_up_wrap();
    logic [2:0] want [10] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2};
    tick(1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 1'b0);
      n_checks++;
      if (count_d !== want[i] || count_jk !== want[i]) begin
        n_fail++;
        $display("FAIL up_wrap[%0d]: got d=%0d jk=%0d expected %0d", i, count_d, count_jk, want[i]);
      end
    end
  endtask

  task automatic test_down_wrap();
    logic [2:0] want [9] = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7};
    tick(1'b1, 1'b1);
    for (int i = 0; i < 9; i++) begin
      tick(1'b0, 1'b1);
      n_checks++;
      if (count_d !== want[i] || count_jk !== want[i]) begin
        n_fail++;
        $display("FAIL down_wrap[%0d]: got d=%0d jk=%0d expected %0d", i, count_d, count_jk, want[i]);
      end
    end
  endtask

  task automatic test_mode_switch();
    logic [2:0] want [3] = '{3'd4, 3'd3, 3'd4};
    logic       mseq [3] = '{1'b1, 1'b1, 1'b0};
    tick(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b0);
    n_checks++;
    if (count_d !== 3'd5 || count_jk !== 3'd5) begin
      n_fail++;
      $display("FAIL switch_start: got d=%0d jk=%0d expected 5", count_d, count_jk);
    end
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, mseq[i]);
      n_checks++;
      if (count_d !== want[i] || count_jk !== want[i]) begin
        n_fail++;
        $display("FAIL switch[%0d]: got d=%0d jk=%0d expected %0d", i, count_d, count_jk, want[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [2:0] want [3] = '{3'd0, 3'd0, 3'd7};
    logic       rseq [3] = '{1'b1, 1'b1, 1'b0};
    tick(1'b1, 1'b1);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    n_checks++;
    if (count_d !== 3'd6 || count_jk !== 3'd6) begin
      n_fail++;
      $display("FAIL reset_mid_start: got d=%0d jk=%0d expected 6", count_d, count_jk);
    end
    for (int i = 0; i < 3; i++) begin
      tick(rseq[i], 1'b1);
      n_checks++;
      if (count_d !== want[i] || count_jk !== want[i]) begin
        n_fail++;
        $display("FAIL reset_mid[%0d]: got d=%0d jk=%0d expected %0d", i, count_d, count_jk, want[i]);
      end
    end
  endtask

  // 25 cycles (250 ns): mode flips at cycle 12, reset pulse at cycle 22.
  task automatic test_equivalence();
    tick(1'b1, 1'b0);
    for (int i = 0; i < 25; i++) begin
      tick((i == 22), (i >= 12));
      n_checks++;
      if (count_d !== count_jk || count_d !== exp_cnt[2:0]) begin
        n_fail++;
        $display("FAIL equiv[%0d]: got d=%0d jk=%0d expected %0d", i, count_d, count_jk, exp_cnt);
      end
    end
  endtask

  task automatic test_random();
    logic r;
    logic m;
    tick(1'b1, 1'b0);
    for (int i = 0; i < 200; i++) begin
      r = ($urandom_range(15) == 0);
      m = $urandom_range(1);
      tick(r, m);
      n_checks++;
      if (count_d !== exp_cnt[2:0]) begin
        n_fail++;
        $display("FAIL random_d[%0d]: got %0d expected %0d", i, count_d, exp_cnt);
      end
      n_checks++;
      if (count_jk !== exp_cnt[2:0]) begin
        n_fail++;
        $display("FAIL random_jk[%0d]: got %0d expected %0d", i, count_jk, exp_cnt);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    mode  = 1'b0;
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_mode_switch();
    test_reset_mid();
    test_equivalence();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
